// File: rtl/mux_n_rr_pkg.sv
// Shared constants and helpers for the N-channel round-robin output mux.
package mux_n_rr_pkg;

  // Selection mode encodings for the mode input
  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Output register states; the state bit doubles as out_valid
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  // Ceiling log2, returns at least 1 so it can size a vector directly
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned span;
    result = 1;
    span   = 2;
    while (span < value) begin
      span   = span << 1;
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mux_n_rr_arbiter.sv
// Rotating-priority search over request lines, starting at ptr and wrapping
// modulo N. Purely combinational; the pointer register lives in the top.
module rr_arbiter
  import mux_n_rr_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned SEL_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] grant,
  output logic             gvalid
);

  // One extra bit so ptr + offset (up to 2N-2) never overflows before the wrap
  localparam int unsigned IDX_W = clog2(N) + 1;

  logic [IDX_W-1:0] idx;

  // Scan offsets from farthest to nearest so the nearest requester wins last
  always_comb begin
    grant  = '0;
    gvalid = |req;
    idx    = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      idx = IDX_W'(ptr) + IDX_W'(k);
      if (idx >= IDX_W'(N)) begin
        idx = idx - IDX_W'(N);
      end
      if (req[idx]) begin
        grant = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mux_n_rr.sv
// N-channel WIDTH-bit multiplexer with a one-word output register,
// valid/ready handshakes on both sides and either external select or
// round-robin channel selection. N must be 2..16 and SEL_W >= clog2(N).
module mux_n_rr
  import mux_n_rr_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 4,
  parameter int unsigned SEL_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel_in,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_sel
);

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [WIDTH-1:0] data_nxt;
  logic [SEL_W-1:0] sel_nxt;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] ptr_nxt;

  logic [SEL_W-1:0] rr_grant;
  logic             rr_gvalid;
  logic             sel_ok;
  logic             sel_valid;
  logic [SEL_W-1:0] grant;
  logic             gvalid;
  logic             space;
  logic             load;
  logic [WIDTH-1:0] grant_data;

  // Round-robin candidate among all valid channels
  rr_arbiter #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_arb (
    .req    (in_valid),
    .ptr    (ptr),
    .grant  (rr_grant),
    .gvalid (rr_gvalid)
  );

  // External-select qualification; an out-of-range select never grants
  always_comb begin
    sel_ok    = 32'(sel_in) < 32'(N);
    sel_valid = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (sel_in == SEL_W'(i)) begin
        sel_valid = in_valid[i];
      end
    end
  end

  // Mode mux between external select and round-robin grant
  always_comb begin
    grant  = sel_in;
    gvalid = sel_ok && sel_valid;
    if (mode == MODE_RR) begin
      grant  = rr_grant;
      gvalid = rr_gvalid;
    end
  end

  // A word loads when the register is empty or being drained this cycle
  always_comb begin
    space = (state == ST_EMPTY) || out_ready;
    load  = space && gvalid && !reset;
  end

  // Data select and one-hot ready decode for the granted channel
  always_comb begin
    grant_data = '0;
    in_ready   = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (grant == SEL_W'(i)) begin
        grant_data  = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = load;
      end
    end
  end

  // Output register next-state: EMPTY/FULL with simultaneous unload and load
  always_comb begin
    state_nxt = state;
    data_nxt  = out_data;
    sel_nxt   = out_sel;
    ptr_nxt   = ptr;
    case (state)
      ST_EMPTY: begin
        if (load) begin
          state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (!load && out_ready) begin
          state_nxt = ST_EMPTY;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    if (load) begin
      data_nxt = grant_data;
      sel_nxt  = grant;
      if (mode == MODE_RR) begin
        ptr_nxt = (grant == SEL_W'(N - 1)) ? '0 : grant + SEL_W'(1);
      end
    end
  end

  // State, output and round-robin pointer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_EMPTY;
      out_data <= '0;
      out_sel  <= '0;
      ptr      <= '0;
    end else begin
      state    <= state_nxt;
      out_data <= data_nxt;
      out_sel  <= sel_nxt;
      ptr      <= ptr_nxt;
    end
  end

  assign out_valid = (state == ST_FULL);

endmodule

// File: tb/tb_mux_n_rr.sv
// Directed bench for mux_n_rr: a 4-channel and a 3-channel instance share
// clock and reset; inputs change on the falling edge, in_ready is sampled
// just after that, registered outputs just after the rising edge.
module tb_mux_n_rr;

  logic clk;
  logic reset;

  logic        mode4, ordy4, ovalid4;
  logic [1:0]  sel4, osel4;
  logic [31:0] data4;
  logic [3:0]  valid4, rdy4;
  logic [7:0]  odata4;

  logic        mode3, ordy3, ovalid3;
  logic [1:0]  sel3, osel3;
  logic [23:0] data3;
  logic [2:0]  valid3, rdy3;
  logic [7:0]  odata3;

  int vectors;
  int miscompares;

  mux_n_rr #(.WIDTH(8), .N(4), .SEL_W(2)) u4 (
    .clk(clk), .reset(reset), .mode(mode4), .sel_in(sel4),
    .in_data(data4), .in_valid(valid4), .in_ready(rdy4),
    .out_data(odata4), .out_valid(ovalid4), .out_ready(ordy4), .out_sel(osel4)
  );

  mux_n_rr #(.WIDTH(8), .N(3), .SEL_W(2)) u3 (
    .clk(clk), .reset(reset), .mode(mode3), .sel_in(sel3),
    .in_data(data3), .in_valid(valid3), .in_ready(rdy3),
    .out_data(odata3), .out_valid(ovalid3), .out_ready(ordy3), .out_sel(osel3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence below ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive4(input logic m, input logic [1:0] s, input logic [3:0] v, input logic r);
    @(negedge clk);
    mode4 = m; sel4 = s; valid4 = v; ordy4 = r;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [7:0] exp1 [4];
  logic [1:0] exp2 [6];
  logic [1:0] exp3 [4];

  initial begin
    vectors = 0; miscompares = 0;
    exp1 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    exp2 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    exp3 = '{2'd1, 2'd3, 2'd3, 2'd3};

    reset = 1'b1;
    mode4 = 1'b0; sel4 = 2'd0; data4 = {8'hDD, 8'hCC, 8'hBB, 8'hAA}; valid4 = 4'hF; ordy4 = 1'b1;
    mode3 = 1'b0; sel3 = 2'd0; data3 = {8'h30, 8'h20, 8'h10}; valid3 = 3'b111; ordy3 = 1'b1;
    #2;
    check("reset_valid", 32'(ovalid4), 32'd0);
    check("reset_data", 32'(odata4), 32'd0);
    check("reset_ready", 32'(rdy4), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // 1: external select walks 0..3
    for (int s = 0; s < 4; s++) begin
      drive4(1'b0, 2'(s), 4'hF, 1'b1);
      check("t1_ready", 32'(rdy4), 32'(4'b0001 << s));
      tick();
      check("t1_data", 32'(odata4), 32'(exp1[s]));
      check("t1_sel", 32'(osel4), 32'(s));
      check("t1_valid", 32'(ovalid4), 32'd1);
    end

    // 2: round-robin with every channel valid
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive4(1'b1, 2'd0, 4'hF, 1'b1);
      check("t2_ready", 32'(rdy4), 32'(4'b0001 << exp2[k]));
      tick();
      check("t2_sel", 32'(osel4), 32'(exp2[k]));
      check("t2_valid", 32'(ovalid4), 32'd1);
    end

    // 3: sparse requesters 1 and 3, then channel 1 drops
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive4(1'b1, 2'd0, (k < 2) ? 4'b1010 : 4'b1000, 1'b1);
      tick();
      check("t3_sel", 32'(osel4), 32'(exp3[k]));
      check("t3_valid", 32'(ovalid4), 32'd1);
    end
    drive4(1'b1, 2'd0, 4'b1010, 1'b1);
    tick();
    check("t3_resume", 32'(osel4), 32'd1);

    // 4: back-pressure holds a loaded word
    do_reset();
    @(negedge clk);
    data4 = {8'hDD, 8'hCC, 8'hBB, 8'h5A};
    drive4(1'b0, 2'd0, 4'b0001, 1'b1);
    tick();
    check("t4_load", 32'(odata4), 32'h5A);
    for (int k = 0; k < 3; k++) begin
      drive4(1'b0, 2'd0, 4'b0001, 1'b0);
      data4[7:0] = 8'(8'h11 * (k + 1));
      #1;
      check("t4_hold_ready", 32'(rdy4), 32'd0);
      tick();
      check("t4_hold_data", 32'(odata4), 32'h5A);
      check("t4_hold_valid", 32'(ovalid4), 32'd1);
    end
    @(negedge clk);
    data4[7:0] = 8'h44;
    drive4(1'b0, 2'd0, 4'b0001, 1'b1);
    check("t4_release_ready", 32'(rdy4), 32'b0001);
    tick();
    check("t4_release_data", 32'(odata4), 32'h44);
    check("t4_release_valid", 32'(ovalid4), 32'd1);

    // 5: N=3 out-of-range select, then reset while FULL
    do_reset();
    @(negedge clk);
    mode3 = 1'b0; sel3 = 2'd0; valid3 = 3'b111; ordy3 = 1'b1;
    #1;
    check("t5_ready0", 32'(rdy3), 32'b001);
    tick();
    check("t5_data0", 32'(odata3), 32'h10);
    check("t5_valid0", 32'(ovalid3), 32'd1);
    @(negedge clk);
    sel3 = 2'd3;
    #1;
    check("t5_sel3_ready", 32'(rdy3), 32'd0);
    tick();
    check("t5_sel3_valid", 32'(ovalid3), 32'd0);
    check("t5_sel3_data", 32'(odata3), 32'h10);
    @(negedge clk);
    mode3 = 1'b1;
    #1;
    check("t5_rr_ready", 32'(rdy3), 32'b001);
    tick();
    check("t5_rr_sel", 32'(osel3), 32'd0);
    @(negedge clk);
    ordy3 = 1'b0;
    #1;
    check("t5_full_ready", 32'(rdy3), 32'd0);
    tick();
    check("t5_full_valid", 32'(ovalid3), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t5_rst_valid", 32'(ovalid3), 32'd0);
    check("t5_rst_data", 32'(odata3), 32'd0);
    check("t5_rst_sel", 32'(osel3), 32'd0);
    check("t5_rst_ready", 32'(rdy3), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    ordy3 = 1'b1;
    #1;
    check("t5_ptr_ready", 32'(rdy3), 32'b001);
    tick();
    check("t5_ptr_sel", 32'(osel3), 32'd0);
    check("t5_ptr_data", 32'(odata3), 32'h10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
